multi_tick_gen: RTL and testbench

//  Parametrised N-channel timebase generator; successor to the fixed two-rate divider.

---
 rtl/tick_gen_pkg.sv | 13 +
 rtl/tick_channel.sv | 69 ++++++
 rtl/multi_tick_gen.sv | 50 +++++
 tb/tb_multi_tick_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel timebase generator.
package tick_gen_pkg;

  localparam int CH_IDX_W = 3;
  localparam int MAX_CH   = 8;

  // Divisor giving one tick every clk_hz/tick_hz cycles.
  function automatic longint unsigned div_for(input longint unsigned clk_hz,
                                              input longint unsigned tick_hz);
    return clk_hz / tick_hz - 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One timebase channel: wrap counter, active/shadow divisor, tick strobe and square wave.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int                CNT_W   = 32,
  parameter logic [CNT_W-1:0]  DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pause,
  input  logic             restart,
  input  logic             we,
  input  logic             now,
  input  logic [CNT_W-1:0] div_in,
  output logic             tick,
  output logic             sq,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_act_reg;
  logic [CNT_W-1:0] div_shd_reg;
  logic             tick_reg;
  logic             sq_reg;
  logic [CNT_W-1:0] shd_next;

  // A write landing on a load cycle must be what gets loaded.
  assign shd_next = we ? div_in : div_shd_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      div_act_reg <= DIV_RST;
      div_shd_reg <= DIV_RST;
      tick_reg    <= 1'b0;
      sq_reg      <= 1'b0;
    end else begin
      div_shd_reg <= shd_next;
      tick_reg    <= 1'b0;
      if (!en) begin
        cnt_reg     <= '0;
        sq_reg      <= 1'b0;
        div_act_reg <= shd_next;
      end else if (restart) begin
        cnt_reg     <= '0;
        sq_reg      <= 1'b0;
        div_act_reg <= shd_next;
      end else if (pause) begin
        cnt_reg     <= cnt_reg;
      end else if (we && now) begin
        cnt_reg     <= '0;
        div_act_reg <= div_in;
      end else if (cnt_reg == div_act_reg) begin
        cnt_reg     <= '0;
        tick_reg    <= 1'b1;
        sq_reg      <= ~sq_reg;
        div_act_reg <= shd_next;
      end else begin
        cnt_reg     <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign tick    = tick_reg;
  assign sq      = sq_reg;
  assign pending = (div_shd_reg != div_act_reg);

endmodule

// File: rtl/multi_tick_gen.sv
// N-channel programmable timebase; decodes the shared config port into per-channel writes.
module multi_tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                       N_CH     = 2,
  parameter int                       CNT_W    = 32,
  parameter logic [N_CH*CNT_W-1:0]    DIV_INIT = {32'd18562499, 32'd371249}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     en,
  input  logic                pause,
  input  logic [N_CH-1:0]     restart,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic                cfg_now,
  output logic [N_CH-1:0]     tick,
  output logic [N_CH-1:0]     sq,
  output logic [N_CH-1:0]     cfg_pending
);

  logic [N_CH-1:0] we_ch;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // Out-of-range channel numbers match no slot and are dropped.
      assign we_ch[gi] = cfg_we && (cfg_ch == CH_IDX_W'(gi));

      tick_channel #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_INIT[gi*CNT_W +: CNT_W])
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .en      (en[gi]),
        .pause   (pause),
        .restart (restart[gi]),
        .we      (we_ch[gi]),
        .now     (cfg_now),
        .div_in  (cfg_div),
        .tick    (tick[gi]),
        .sq      (sq[gi]),
        .pending (cfg_pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_tick_gen.sv
// Scoreboarded bench: a countdown-per-period reference model predicts every cycle's outputs.
module tb_multi_tick_gen;

  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam logic [N_CH*CNT_W-1:0] DIV_INIT = {8'd5, 8'd3};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N_CH-1:0]  en = '0;
  logic             pause = 1'b0;
  logic [N_CH-1:0]  restart = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic             cfg_now = 1'b0;
  logic [N_CH-1:0]  tick, sq, cfg_pending;

  multi_tick_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .clk(clk), .rst(rst), .en(en), .pause(pause), .restart(restart),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_now(cfg_now),
    .tick(tick), .sq(sq), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] sq;
    logic [N_CH-1:0] pend;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: remaining running cycles until the next tick of each channel.
  int              rem [N_CH];
  int              act [N_CH];
  int              shd [N_CH];
  int              init_div [N_CH];
  logic [N_CH-1:0] m_tick, m_sq;
  logic            rst_want = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      act[i] = init_div[i];
      shd[i] = init_div[i];
      rem[i] = act[i] + 1;
    end
    m_tick = '0;
    m_sq   = '0;
  endtask

  task automatic model_step();
    exp_t e;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        bit wr;
        int nshd;
        wr        = cfg_we && (int'(cfg_ch) == i);
        nshd      = wr ? int'(cfg_div) : shd[i];
        m_tick[i] = 1'b0;
        if (!en[i] || restart[i]) begin
          act[i]  = nshd;
          rem[i]  = act[i] + 1;
          m_sq[i] = 1'b0;
        end else if (pause) begin
          // frozen
        end else if (wr && cfg_now) begin
          act[i] = int'(cfg_div);
          rem[i] = act[i] + 1;
        end else begin
          rem[i]--;
          if (rem[i] == 0) begin
            m_tick[i] = 1'b1;
            m_sq[i]   = ~m_sq[i];
            act[i]    = nshd;
            rem[i]    = act[i] + 1;
          end
        end
        shd[i] = nshd;
      end
    end
    e.tick = m_tick;
    e.sq   = m_sq;
    for (int i = 0; i < N_CH; i++) e.pend[i] = (shd[i] != act[i]);
    q.push_back(e);
  endtask

  task automatic drive(input logic [N_CH-1:0] en_v, input logic pause_v,
                       input logic [N_CH-1:0] rs_v, input logic we_v,
                       input logic [2:0] ch_v, input logic [CNT_W-1:0] div_v,
                       input logic now_v);
    @(negedge clk);
    rst     = rst_want;
    en      = en_v;
    pause   = pause_v;
    restart = rs_v;
    cfg_we  = we_v;
    cfg_ch  = ch_v;
    cfg_div = div_v;
    cfg_now = now_v;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(2'b11, 1'b0, 2'b00, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic check(input string name, input logic [N_CH-1:0] act_v,
                       input logic [N_CH-1:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act_v, exp_v);
    end
  endtask

  // Asynchronous reset between edges with a write to a nonexistent channel.
  task automatic inject_reset();
    @(posedge clk);
    #3;
    rst     = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 3'd3;
    cfg_div = 8'd1;
    #1;
    check("rst_tick", tick, '0);
    check("rst_sq", sq, '0);
    check("rst_pending", cfg_pending, '0);
    rst_want = 1'b1;
    drive(2'b11, 1'b0, 2'b00, 1'b1, 3'd3, 8'd1, 1'b1);
    rst_want = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("tick", tick, e.tick);
      check("sq", sq, e.sq);
      check("pending", cfg_pending, e.pend);
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < N_CH; i++) init_div[i] = int'(DIV_INIT[i*CNT_W +: CNT_W]);
    model_reset();

    #1 rst = 1'b1;
    #1;
    check("init_tick", tick, '0);
    check("init_sq", sq, '0);
    check("init_pending", cfg_pending, '0);
    rst_want = 1'b1;
    idle(2);
    rst_want = 1'b0;

    // Free-running periods 4 and 6.
    idle(26);

    // Deferred divisor change mid-period.
    guard = 0;
    while (rem[0] != 2 && guard < 20) begin idle(1); guard++; end
    drive(2'b11, 1'b0, 2'b00, 1'b1, 3'd0, 8'd1, 1'b0);
    idle(12);

    // Immediate change to div=0 on ch1.
    drive(2'b11, 1'b0, 2'b00, 1'b1, 3'd1, 8'd0, 1'b1);
    idle(8);

    // Pause with ch0 at count 2.
    drive(2'b11, 1'b0, 2'b00, 1'b1, 3'd0, 8'd3, 1'b1);
    idle(2);
    for (int k = 0; k < 10; k++) drive(2'b11, 1'b1, 2'b00, 1'b0, 3'd0, 8'd0, 1'b0);
    idle(6);

    // Restart coinciding with a wrap.
    guard = 0;
    while (rem[0] != 1 && guard < 20) begin idle(1); guard++; end
    drive(2'b11, 1'b0, 2'b01, 1'b0, 3'd0, 8'd0, 1'b0);
    idle(10);

    inject_reset();
    idle(10);

    for (int k = 0; k < 3000; k++) begin
      logic [N_CH-1:0] e_v, r_v;
      e_v = ($urandom_range(0, 19) == 0) ? N_CH'($urandom) : 2'b11;
      r_v = ($urandom_range(0, 29) == 0) ? N_CH'($urandom) : 2'b00;
      if ($urandom_range(0, 499) == 0) inject_reset();
      drive(e_v, ($urandom_range(0, 9) == 0), r_v, ($urandom_range(0, 9) == 0),
            3'($urandom_range(0, 3)), 8'($urandom_range(0, 9)), 1'($urandom));
    end

    idle(1);
    @(posedge clk);
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
